ahb_master: RTL and testbench

AHB-Lite bus initiator that converts single-command requests from local logic into AHB address/data phases toward the team's `slave` block. It supports SINGLE, INCR4 and WRAP4 bursts with pipelined address/data phases, wait-state stretching through HREADY, and two-cycle ERROR handling. It sits between a local command/data port and the AHB fabric.

---
 rtl/ahb_master.sv | 278 +++++++++++++++++++++++++++
 tb/tb_ahb_master.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master.sv
`default_nettype none
// ============================================================================
// Module   : ahb_master
// Purpose  : AHB-Lite bus initiator. Turns one local command (SINGLE, INCR4
//            or WRAP4) into pipelined AHB address/data phases. Handles
//            HREADY wait states and the two-cycle ERROR response.
// Ports    : HCLK/HRST         - bus clock, asynchronous active-low reset
//            cmd_*             - command request/handshake (cmd_ready in IDLE)
//            wr_data/valid/pop - local write-beat source
//            rd_data/valid     - registered read beats
//            done/err          - one-cycle command completion pulses
//            H*                - AHB-Lite initiator signals
// Options  : AHB_MST_BUSY_EN   - insert BUSY on 4-beat writes while wr_valid
//                                is low at the issue of beats 2..4
// Revision : 1.0 - initial release
// ============================================================================
module ahb_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRST,
  // local command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [1:0]        cmd_size,
  input  logic [2:0]        cmd_burst,
  input  logic [3:0]        cmd_prot,
  input  logic              cmd_lock,
  // local data ports
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  // AHB-Lite
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [1:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [1:0]        HTRANS,
  output logic              HMASTERLOCK,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic [DATA_W-1:0] HRDATA
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_LAST = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [2:0] BURST_SINGLE = 3'd0;
  localparam logic [2:0] BURST_WRAP4  = 3'd2;
  localparam logic [2:0] BURST_INCR4  = 3'd3;

  state_t              state_q,    state_d;
  logic [ADDR_W-1:0]   haddr_q,    haddr_d;
  logic                hwrite_q,   hwrite_d;
  logic [1:0]          hsize_q,    hsize_d;
  logic [2:0]          hburst_q,   hburst_d;
  logic [3:0]          hprot_q,    hprot_d;
  logic [1:0]          htrans_q,   htrans_d;
  logic                hlock_q,    hlock_d;
  logic [DATA_W-1:0]   hwdata_q,   hwdata_d;
  logic [DATA_W-1:0]   rd_data_q,  rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                done_q,     done_d;
  logic                err_q,      err_d;
  // address phases still to be accepted, counting the one on the bus
  logic [2:0]          beats_q,    beats_d;
  // a real (NONSEQ/SEQ) transfer is in its data phase this cycle
  logic                dphase_q,   dphase_d;

  logic [ADDR_W-1:0]   addr_inc;
  logic [ADDR_W-1:0]   wrap_mask;
  logic [ADDR_W-1:0]   addr_step;
  logic [ADDR_W-1:0]   next_addr;
  logic                cmd_accept;
  logic                addr_real;
  logic                addr_take;
  logic                dphase_err;
  logic                rd_take;
  logic                stall_write;

  // Next beat address: linear for INCR4, wrapped inside a 4-beat block for WRAP4.
  always_comb begin
    addr_inc  = ADDR_W'(1) << hsize_q;
    wrap_mask = (ADDR_W'(4) << hsize_q) - ADDR_W'(1);
    addr_step = haddr_q + addr_inc;
    if (hburst_q == BURST_WRAP4) begin
      next_addr = (haddr_q & ~wrap_mask) | (addr_step & wrap_mask);
    end else begin
      next_addr = addr_step;
    end
  end

`ifdef AHB_MST_BUSY_EN
  // Write beats 2..4 are held off with BUSY while the local side has no data.
  assign stall_write = hwrite_q & ~wr_valid;
`else
  // Write data is assumed available for every beat once the command is taken.
  assign stall_write = 1'b0;
`endif

  assign cmd_accept = (state_q == S_IDLE) && cmd_valid && (!cmd_write || wr_valid);
  assign addr_real  = (htrans_q == TRANS_NONSEQ) || (htrans_q == TRANS_SEQ);
  assign dphase_err = dphase_q && HRESP;
  // An erroring data phase cancels the address phase that overlaps it.
  assign addr_take  = (state_q == S_ADDR) && HREADY && addr_real && !dphase_err;
  assign rd_take    = dphase_q && HREADY && !HRESP && !hwrite_q;
  assign wr_pop     = addr_take && hwrite_q;

  always_comb begin
    state_d    = state_q;
    haddr_d    = haddr_q;
    hwrite_d   = hwrite_q;
    hsize_d    = hsize_q;
    hburst_d   = hburst_q;
    hprot_d    = hprot_q;
    htrans_d   = htrans_q;
    hlock_d    = hlock_q;
    hwdata_d   = hwdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    beats_d    = beats_q;
    dphase_d   = HREADY ? addr_take : dphase_q;

    if (rd_take) begin
      rd_data_d  = HRDATA;
      rd_valid_d = 1'b1;
    end
    if (wr_pop) begin
      hwdata_d = wr_data;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_accept) begin
          state_d  = S_ADDR;
          haddr_d  = cmd_addr;
          hwrite_d = cmd_write;
          hsize_d  = cmd_size;
          hprot_d  = cmd_prot;
          hlock_d  = cmd_lock;
          htrans_d = TRANS_NONSEQ;
          if ((cmd_burst == BURST_WRAP4) || (cmd_burst == BURST_INCR4)) begin
            hburst_d = cmd_burst;
            beats_d  = 3'd4;
          end else begin
            hburst_d = BURST_SINGLE;
            beats_d  = 3'd1;
          end
        end
      end

      S_ADDR: begin
        if (dphase_err && HREADY) begin
          err_d    = 1'b1;
          htrans_d = TRANS_IDLE;
          hlock_d  = 1'b0;
          state_d  = S_IDLE;
        end else if (dphase_err) begin
          // First ERROR cycle: withdraw the pending beats right away.
          htrans_d = TRANS_IDLE;
          state_d  = S_ERR;
        end else if (HREADY) begin
          if (addr_real) begin
            if (beats_q == 3'd1) begin
              htrans_d = TRANS_IDLE;
              state_d  = S_LAST;
            end else begin
              haddr_d  = next_addr;
              beats_d  = beats_q - 3'd1;
              htrans_d = stall_write ? TRANS_BUSY : TRANS_SEQ;
            end
          end else if (!stall_write) begin
            // BUSY already carries the next address; only the type changes.
            htrans_d = TRANS_SEQ;
          end
        end
      end

      S_LAST: begin
        if (dphase_err) begin
          if (HREADY) begin
            err_d   = 1'b1;
            hlock_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_ERR;
          end
        end else if (HREADY) begin
          done_d  = 1'b1;
          hlock_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      S_ERR: begin
        if (HREADY) begin
          err_d   = 1'b1;
          hlock_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRST) begin
    if (!HRST) begin
      state_q    <= S_IDLE;
      haddr_q    <= '0;
      hwrite_q   <= 1'b0;
      hsize_q    <= 2'd0;
      hburst_q   <= 3'd0;
      hprot_q    <= 4'd0;
      htrans_q   <= TRANS_IDLE;
      hlock_q    <= 1'b0;
      hwdata_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      beats_q    <= 3'd0;
      dphase_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      haddr_q    <= haddr_d;
      hwrite_q   <= hwrite_d;
      hsize_q    <= hsize_d;
      hburst_q   <= hburst_d;
      hprot_q    <= hprot_d;
      htrans_q   <= htrans_d;
      hlock_q    <= hlock_d;
      hwdata_q   <= hwdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
      beats_q    <= beats_d;
      dphase_q   <= dphase_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign HADDR       = haddr_q;
  assign HWRITE      = hwrite_q;
  assign HSIZE       = hsize_q;
  assign HBURST      = hburst_q;
  assign HPROT       = hprot_q;
  assign HTRANS      = htrans_q;
  assign HMASTERLOCK = hlock_q;
  assign HWDATA      = hwdata_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_master
// Purpose  : Directed, self-checking bench for ahb_master. Each scenario is
//            stepped cycle by cycle against hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ahb_master;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRST;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_lock;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_size;
  logic [2:0]  cmd_burst;
  logic [3:0]  cmd_prot;
  logic [31:0] wr_data, rd_data, HADDR, HWDATA, HRDATA;
  logic        wr_valid, wr_pop, rd_valid, done, err;
  logic        HWRITE, HMASTERLOCK, HREADY, HRESP;
  logic [1:0]  HSIZE, HTRANS;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;
  int n_rd     = 0;
  int n_done   = 0;
  int n_err    = 0;
  int base;

  ahb_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRST(HRST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .cmd_prot(cmd_prot), .cmd_lock(cmd_lock),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_pop(wr_pop),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HTRANS(HTRANS), .HMASTERLOCK(HMASTERLOCK),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  // Pulse counters, sampled mid-cycle.
  always @(negedge HCLK) begin
    if (wr_pop)   n_pop++;
    if (rd_valid) n_rd++;
    if (done)     n_done++;
    if (err)      n_err++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // Present a command for one cycle; returns in the NONSEQ cycle.
  task automatic issue(input logic [31:0] a, input logic wr, input logic [1:0] sz,
                       input logic [2:0] bu, input logic [3:0] pr, input logic lk,
                       input logic [31:0] wd);
    cmd_valid = 1'b1; cmd_addr = a; cmd_write = wr; cmd_size = sz;
    cmd_burst = bu; cmd_prot = pr; cmd_lock = lk;
    wr_valid = 1'b1; wr_data = wd;
    HREADY = 1'b1; HRESP = 1'b0;
    #1;
    check("accept.cmd_ready", cmd_ready, 1);
    check("accept.wr_pop", wr_pop, 0);
    step();
    cmd_valid = 1'b0;
  endtask

  // Drive HREADY/HRESP for one cycle, check bus outputs, advance.
  task automatic cyc(input string tag, input logic rdy, input logic resp,
                     input logic [1:0] etr, input logic [31:0] ead, input logic epop);
    HREADY = rdy; HRESP = resp;
    #1;
    check({tag, ".htrans"}, HTRANS, etr);
    check({tag, ".haddr"},  HADDR,  ead);
    check({tag, ".wr_pop"}, wr_pop, epop);
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRST = 1'b0; cmd_valid = 0; cmd_addr = 0; cmd_write = 0; cmd_size = 0;
    cmd_burst = 0; cmd_prot = 0; cmd_lock = 0; wr_data = 0; wr_valid = 0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 0;
    #2;
    check("rst.htrans", HTRANS, T_IDLE);
    check("rst.haddr", HADDR, 0);
    check("rst.done", done, 0);
    check("rst.cmd_ready", cmd_ready, 1);
    step(); step();
    HRST = 1'b1;
    step();

    // ---- SINGLE write, addr 5, size 0, data 45 ----
    issue(32'd5, 1'b1, 2'd0, 3'd0, 4'h3, 1'b1, 32'd45);
    check("s1.hwrite", HWRITE, 1);
    check("s1.hprot", HPROT, 4'h3);
    check("s1.hburst", HBURST, 0);
    check("s1.lock", HMASTERLOCK, 1);
    check("s1.cmd_ready", cmd_ready, 0);
    cyc("s1.c1", 1, 0, T_NONSEQ, 32'd5, 1);
    check("s1.hwdata", HWDATA, 45);
    check("s1.lock_dp", HMASTERLOCK, 1);
    cyc("s1.c2", 1, 0, T_IDLE, 32'd5, 0);
    check("s1.done", done, 1);
    check("s1.lock_off", HMASTERLOCK, 0);
    check("s1.ready_back", cmd_ready, 1);
    step();
    check("s1.done_pulse", done, 0);

    // ---- INCR4 write 0x10 size 2, two wait states on beat 2 ----
    base = n_pop;
    issue(32'h10, 1'b1, 2'd2, 3'd3, 4'h0, 1'b0, 32'hA0);
    check("i4w.hburst", HBURST, 3);
    cyc("i4w.c1", 1, 0, T_NONSEQ, 32'h10, 1);
    wr_data = 32'hA1;
    check("i4w.hwdata0", HWDATA, 32'hA0);
    cyc("i4w.c2", 0, 0, T_SEQ, 32'h14, 0);
    check("i4w.hwdata_frz", HWDATA, 32'hA0);
    cyc("i4w.c3", 0, 0, T_SEQ, 32'h14, 0);
    check("i4w.hwdata_frz2", HWDATA, 32'hA0);
    cyc("i4w.c4", 1, 0, T_SEQ, 32'h14, 1);
    check("i4w.hwdata1", HWDATA, 32'hA1);
    wr_data = 32'hA2;
    cyc("i4w.c5", 1, 0, T_SEQ, 32'h18, 1);
    check("i4w.hwdata2", HWDATA, 32'hA2);
    wr_data = 32'hA3;
    cyc("i4w.c6", 1, 0, T_SEQ, 32'h1C, 1);
    check("i4w.hwdata3", HWDATA, 32'hA3);
    cyc("i4w.c7", 1, 0, T_IDLE, 32'h1C, 0);
    check("i4w.done", done, 1);
    check("i4w.pops", n_pop - base, 4);
    step();

    // ---- WRAP4 read 0x38 size 2, HRDATA = beat address ----
    base = n_rd;
    issue(32'h38, 1'b0, 2'd2, 3'd2, 4'h1, 1'b0, 32'h0);
    check("w4r.hburst", HBURST, 2);
    cyc("w4r.c1", 1, 0, T_NONSEQ, 32'h38, 0);
    HRDATA = 32'h38;
    cyc("w4r.c2", 1, 0, T_SEQ, 32'h3C, 0);
    check("w4r.rv1", rd_valid, 1);
    check("w4r.rd1", rd_data, 32'h38);
    HRDATA = 32'h3C;
    cyc("w4r.c3", 1, 0, T_SEQ, 32'h30, 0);
    check("w4r.rd2", rd_data, 32'h3C);
    HRDATA = 32'h30;
    cyc("w4r.c4", 1, 0, T_SEQ, 32'h34, 0);
    check("w4r.rd3", rd_data, 32'h30);
    HRDATA = 32'h34;
    cyc("w4r.c5", 1, 0, T_IDLE, 32'h34, 0);
    check("w4r.rd4", rd_data, 32'h34);
    check("w4r.done", done, 1);
    step();
    check("w4r.rv_end", rd_valid, 0);
    check("w4r.pulses", n_rd - base, 4);

    // ---- INCR4 read 0x40, ERROR on beat 2 ----
    base = n_rd;
    issue(32'h40, 1'b0, 2'd2, 3'd3, 4'h0, 1'b1, 32'h0);
    cyc("er.c1", 1, 0, T_NONSEQ, 32'h40, 0);
    HRDATA = 32'h111;
    cyc("er.c2", 1, 0, T_SEQ, 32'h44, 0);
    check("er.rv1", rd_valid, 1);
    check("er.rd1", rd_data, 32'h111);
    HRDATA = 32'h222;
    cyc("er.err1", 0, 1, T_SEQ, 32'h48, 0);
    check("er.rv_err", rd_valid, 0);
    cyc("er.err2", 1, 1, T_IDLE, 32'h48, 0);
    HRESP = 1'b0;
    check("er.err", err, 1);
    check("er.no_done", done, 0);
    check("er.rv_none", rd_valid, 0);
    check("er.lock_off", HMASTERLOCK, 0);
    check("er.ready", cmd_ready, 1);
    step();
    check("er.err_pulse", err, 0);
    check("er.rd_pulses", n_rd - base, 1);

    // ---- unsupported burst code runs as SINGLE ----
    issue(32'h20, 1'b0, 2'd1, 3'd1, 4'h0, 1'b0, 32'h0);
    check("sg.hburst", HBURST, 0);
    check("sg.hsize", HSIZE, 1);
    cyc("sg.c1", 1, 0, T_NONSEQ, 32'h20, 0);
    HRDATA = 32'h55;
    cyc("sg.c2", 1, 0, T_IDLE, 32'h20, 0);
    check("sg.done", done, 1);
    check("sg.rd", rd_data, 32'h55);
    step();

    // ---- INCR4 write 0x80 size 1, wr_valid low before beat 3 ----
    issue(32'h80, 1'b1, 2'd1, 3'd3, 4'h0, 1'b0, 32'hB0);
    cyc("bz.c1", 1, 0, T_NONSEQ, 32'h80, 1);
    wr_data = 32'hB1; wr_valid = 1'b0;
    cyc("bz.c2", 1, 0, T_SEQ, 32'h82, 1);
    check("bz.hwdata1", HWDATA, 32'hB1);
`ifdef AHB_MST_BUSY_EN
    wr_data = 32'hB2;
    cyc("bz.busy1", 1, 0, T_BUSY, 32'h84, 0);
    cyc("bz.busy2", 1, 0, T_BUSY, 32'h84, 0);
    wr_valid = 1'b1;
    cyc("bz.busy3", 1, 0, T_BUSY, 32'h84, 0);
    check("bz.hwdata_hold", HWDATA, 32'hB1);
    cyc("bz.c3", 1, 0, T_SEQ, 32'h84, 1);
    check("bz.hwdata2", HWDATA, 32'hB2);
    wr_data = 32'hB3;
    cyc("bz.c4", 1, 0, T_SEQ, 32'h86, 1);
`else
    wr_data = 32'hB2;
    cyc("bz.c3", 1, 0, T_SEQ, 32'h84, 1);
    check("bz.hwdata2", HWDATA, 32'hB2);
    wr_data = 32'hB3; wr_valid = 1'b1;
    cyc("bz.c4", 1, 0, T_SEQ, 32'h86, 1);
`endif
    check("bz.hwdata3", HWDATA, 32'hB3);
    cyc("bz.c5", 1, 0, T_IDLE, 32'h86, 0);
    check("bz.done", done, 1);
    step();

    // ---- reset during beat 3 of an INCR4 write ----
    issue(32'h100, 1'b1, 2'd2, 3'd3, 4'h5, 1'b1, 32'hC0);
    cyc("rs.c1", 1, 0, T_NONSEQ, 32'h100, 1);
    wr_data = 32'hC1;
    cyc("rs.c2", 1, 0, T_SEQ, 32'h104, 1);
    check("rs.pre_haddr", HADDR, 32'h108);
    HRST = 1'b0;
    #1;
    check("rs.htrans", HTRANS, 0);
    check("rs.haddr", HADDR, 0);
    check("rs.hwrite", HWRITE, 0);
    check("rs.hsize", HSIZE, 0);
    check("rs.hburst", HBURST, 0);
    check("rs.hprot", HPROT, 0);
    check("rs.lock", HMASTERLOCK, 0);
    check("rs.hwdata", HWDATA, 0);
    check("rs.rd_data", rd_data, 0);
    check("rs.rv", rd_valid, 0);
    check("rs.wr_pop", wr_pop, 0);
    check("rs.done", done, 0);
    check("rs.err", err, 0);
    step(); step();
    HRST = 1'b1;
    step(); step();
    check("rs.ready", cmd_ready, 1);
    check("rs.idle", HTRANS, T_IDLE);
    check("tot.done", n_done, 5);
    check("tot.err", n_err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
